// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - programmable serial pattern detector with saturating match counter
//
// Purpose:
//   Shifts qualified serial bits into a history register and compares the most
//   recent PAT_W bits against a loadable pattern. A match raises a one-cycle
//   registered pulse and bumps a saturating counter. Overlapping or
//   non-overlapping detection is selectable per match.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   enable       in   detector run enable; low forces IDLE and flushes history
//   pat_load     in   load pat_in into the pattern register and flush history
//   pat_in       in   [PAT_W-1:0] new pattern value
//   overlap      in   1 = keep history after a match, 0 = restart fill after a match
//   data_in      in   serial data bit
//   data_valid   in   data_in qualifier
//   clear_count  in   synchronous match counter clear (wins over increment)
//   match        out  registered one-cycle pulse per match event
//   match_count  out  [CNT_W-1:0] saturating match total
//   count_sat    out  match_count is all-ones
//   state_out    out  [1:0] state register (IDLE=00 FILL=01 HUNT=10 MATCH=11)

module seq_detector #(
  parameter int               PAT_W     = 4,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] PAT_RESET = 4'b1011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             clear_count,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic [1:0]       state_out
);

  // Fill counter must represent 0..PAT_W inclusive.
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    HUNT  = 2'b10,
    MATCH = 2'b11
  } state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] pattern, pattern_n;
  logic [PAT_W-1:0] hist, hist_n;
  logic [FW-1:0]    fill, fill_n;

  logic [PAT_W-1:0] hist_shift;
  logic [FW-1:0]    fill_inc;
  logic             accept;
  logic             match_ev;

  // Next-state, datapath and match-event decode.
  always_comb begin
    state_n    = state;
    pattern_n  = pattern;
    hist_n     = hist;
    fill_n     = fill;
    accept     = 1'b0;
    match_ev   = 1'b0;
    hist_shift = {hist[PAT_W-2:0], data_in};
    fill_inc   = (fill == FULL) ? FULL : fill + FW'(1);

    if (pat_load) begin
      // The data bit presented in a load cycle is dropped.
      pattern_n = pat_in;
      hist_n    = '0;
      fill_n    = '0;
      state_n   = enable ? FILL : IDLE;
    end else if (!enable) begin
      hist_n  = '0;
      fill_n  = '0;
      state_n = IDLE;
    end else if (state == IDLE) begin
      // Leaving IDLE costs one edge; no bit is accepted on it.
      state_n = FILL;
    end else begin
      accept = data_valid;
      if (accept) begin
        match_ev = (fill_inc == FULL) && (hist_shift == pattern);
        hist_n   = hist_shift;
        // Non-overlapping mode restarts the fill; stale history bits are
        // harmless because a new match needs PAT_W fresh bits again.
        fill_n   = (match_ev && !overlap) ? '0 : fill_inc;
      end

      case (state)
        FILL: begin
          if (match_ev)
            state_n = MATCH;
          else if (accept && (fill_inc == FULL))
            state_n = HUNT;
        end
        HUNT: begin
          if (match_ev)
            state_n = MATCH;
        end
        MATCH: begin
          if (match_ev)
            state_n = MATCH;
          else if (fill_n < FULL)
            state_n = FILL;
          else
            state_n = HUNT;
        end
        default: state_n = state;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pattern <= PAT_RESET;
      hist    <= '0;
      fill    <= '0;
      match   <= 1'b0;
    end else begin
      state   <= state_n;
      pattern <= pattern_n;
      hist    <= hist_n;
      fill    <= fill_n;
      match   <= match_ev;
    end
  end

  // Saturating match counter; clear wins over a coincident increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
    end else if (clear_count) begin
      match_count <= '0;
    end else if (match_ev && !count_sat) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

  assign count_sat = &match_count;
  assign state_out = state;

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - scoreboard bench for seq_detector with a queue-based reference model

module tb_seq_detector;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          pat_load;
  logic [PW-1:0] pat_in;
  logic          overlap;
  logic          data_in;
  logic          data_valid;
  logic          clear_count;

  logic          match_a, count_sat_a;
  logic [7:0]    match_count_a;
  logic [1:0]    state_a;
  logic          match_b, count_sat_b;
  logic [1:0]    match_count_b;
  logic [1:0]    state_b;

  always #5 clk = ~clk;

  seq_detector #(.PAT_W(PW), .CNT_W(8), .PAT_RESET(4'b1011)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .data_in(data_in),
    .data_valid(data_valid), .clear_count(clear_count),
    .match(match_a), .match_count(match_count_a), .count_sat(count_sat_a),
    .state_out(state_a)
  );

  seq_detector #(.PAT_W(PW), .CNT_W(2), .PAT_RESET(4'b1011)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .data_in(data_in),
    .data_valid(data_valid), .clear_count(clear_count),
    .match(match_b), .match_count(match_count_b), .count_sat(count_sat_b),
    .state_out(state_b)
  );

  typedef struct {
    logic       m;
    logic [7:0] ca;
    logic [1:0] cb;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];

  int tests = 0;
  int fails = 0;

  // Reference model: accepted bits since the last flush, newest at the back.
  bit          running;
  bit [PW-1:0] mpat;
  bit          win[$];
  int          ca, cb;
  bit          mm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one edge's inputs, advance the model, and queue its expectation.
  task automatic step(input int rs, input int en, input int ld, input int pi,
                      input int ov, input int d, input int v, input int clr);
    exp_t e;
    reset       = (rs != 0);
    enable      = (en != 0);
    pat_load    = (ld != 0);
    pat_in      = PW'(pi);
    overlap     = (ov != 0);
    data_in     = (d != 0);
    data_valid  = (v != 0);
    clear_count = (clr != 0);

    mm = 1'b0;
    if (rs == 0) begin
      running = 1'b0;
      mpat    = 4'b1011;
      win.delete();
      ca = 0;
      cb = 0;
    end else begin
      if (ld != 0) begin
        mpat = PW'(pi);
        win.delete();
        running = (en != 0);
      end else if (en == 0) begin
        win.delete();
        running = 1'b0;
      end else if (!running) begin
        running = 1'b1;
      end else if (v != 0) begin
        win.push_back(d != 0);
        if (win.size() > PW) void'(win.pop_front());
        if (win.size() == PW) begin
          mm = 1'b1;
          for (int i = 0; i < PW; i++)
            if (win[i] != mpat[PW-1-i]) mm = 1'b0;
        end
        if (mm && ov == 0) win.delete();
      end
      if (clr != 0) begin
        ca = 0;
        cb = 0;
      end else if (mm) begin
        if (ca < 255) ca++;
        if (cb < 3) cb++;
      end
    end

    e.m  = mm;
    e.ca = 8'(ca);
    e.cb = 2'(cb);
    if (!running)            e.st = 2'b00;
    else if (mm)             e.st = 2'b11;
    else if (win.size() < PW) e.st = 2'b01;
    else                     e.st = 2'b10;

    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic bit_in(input int d, input int ov);
    step(1, 1, 0, 0, ov, d, 1, 0);
  endtask

  task automatic load(input int pi);
    step(1, 1, 1, pi, 0, $urandom_range(0, 1), 1, 0);
  endtask

  // Send n bits MSB first, with gap invalid cycles after each bit.
  task automatic stream(input logic [15:0] b, input int n, input int ov, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in(b[i] ? 1 : 0, ov);
      for (int g = 0; g < gap; g++)
        step(1, 1, 0, 0, ov, $urandom_range(0, 1), 0, 0);
    end
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("match_a",       match_a,       e.m);
        check("match_count_a", match_count_a, e.ca);
        check("count_sat_a",   count_sat_a,   (e.ca == 8'hff));
        check("state_a",       state_a,       e.st);
        check("match_b",       match_b,       e.m);
        check("match_count_b", match_count_b, e.cb);
        check("count_sat_b",   count_sat_b,   (e.cb == 2'b11));
        check("state_b",       state_b,       e.st);
      end
    end
  end

  initial begin
    // Reset held with random inputs.
    step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);
    check("reset_match", match_a, 0);
    check("reset_state", state_a, 0);
    check("reset_count", match_count_a, 0);
    for (int i = 0; i < 3; i++)
      step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1));

    // Reset pattern is 1011.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    stream(16'b1011, 4, 0, 0);
    check("req18_match_after_reset", match_a, 1);

    // Non-overlapping then overlapping on 1011011.
    load(4'b1011);
    stream(16'b1011011, 7, 0, 0);
    check("req19_state_fill", state_a, 2'b01);
    load(4'b1011);
    stream(16'b1011011, 7, 1, 0);
    check("req19_match_bit7", match_a, 1);

    // Gapped stream.
    load(4'b1011);
    stream(16'b1011, 4, 0, 3);

    // Saturation with all-ones pattern.
    step(1, 1, 0, 0, 0, 0, 0, 1);
    load(4'b1111);
    stream(16'hff, 8, 1, 0);
    check("req21_count_b", match_count_b, 3);
    check("req21_sat_b", count_sat_b, 1);
    step(1, 1, 0, 0, 1, 1, 1, 1);
    check("req21_clear_match", match_b, 1);
    check("req21_clear_count", match_count_b, 0);

    // Pattern load mid-fill.
    load(4'b1011);
    stream(16'b101, 3, 0, 0);
    load(4'b0110);
    check("req22_state_fill", state_a, 2'b01);
    stream(16'b0110, 4, 0, 0);
    check("req22_match", match_a, 1);

    // Enable dropped in HUNT.
    load(4'b1011);
    stream(16'b1111, 4, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    check("req23_idle", state_a, 2'b00);
    step(1, 1, 0, 0, 0, 1, 1, 0);
    stream(16'b1011, 4, 0, 0);

    // Asynchronous reset while in MATCH.
    load(4'b1011);
    stream(16'b1011, 4, 0, 0);
    check("req17_in_match", state_a, 2'b11);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("req17_async_match", match_a, 0);
    check("req17_async_state", state_a, 0);
    check("req17_async_count", match_count_a, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    check("req17_fill", state_a, 2'b01);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1,
           ($urandom_range(0, 15) != 0) ? 1 : 0,
           ($urandom_range(0, 40) == 0) ? 1 : 0,
           $urandom_range(0, 15),
           $urandom_range(0, 1),
           $urandom_range(0, 1),
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           ($urandom_range(0, 80) == 0) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    check("queue_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
